dc_svc_rsp: RTL and testbench

DC_SVC_RSP -- requirements
Module: dc_svc_rsp

---
 rtl/dc_svc_pkg.sv | 24 ++
 rtl/dc_svc_ltc.sv | 24 ++
 rtl/dc_svc_rsp.sv | 111 +++++++++++
 tb/tb_dc_svc_rsp.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_svc_pkg.sv
// Shared types and constants for the DC service-read responder.
// Service-word bit positions, FSM state encoding and the cjmp opcode.
package dc_svc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CLEAR = 2'd2
    } svc_state_e;

    localparam logic [4:0] CJMP_OP = 5'b00001;

    localparam int B_EVNT = 12;
    localparam int B_IRQ7 = 11;
    localparam int B_IRQ4 = 8;
    localparam int B_ACLO = 7;
    localparam int B_HALT = 5;
    localparam int B_CC   = 4;
    localparam int B_MMU  = 3;
    localparam int B_PAR  = 2;
    localparam int B_TMO  = 1;
    localparam int B_DCLO = 0;

endpackage

// File: rtl/dc_svc_ltc.sv
// Line-clock prescaler: counts 0..LTC_DIV-1 and pulses tick on the
// wrap cycle. Only instantiated when DC_SVC_LTC_EN is defined.
module dc_svc_ltc #(
    parameter logic [15:0] LTC_DIV = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [15:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LTC_DIV - 16'd1);

    always_comb begin
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dc_svc_rsp.sv
// Service-read responder and conditional-jump M11 driver for the MIB.
// Define DC_SVC_LTC_EN to enable the line-clock event prescaler.
module dc_svc_rsp
    import dc_svc_pkg::*;
#(
    parameter logic [15:0] LTC_DIV = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mib_in,
    input  logic        mib_vld,
    input  logic        cond,
    output logic        m11_out,
    output logic        m11_oe,
    input  logic [3:0]  irq,
    input  logic        halt_req,
    input  logic        bus_tmo,
    input  logic        aclo_n,
    input  logic        dclo_n,
    input  logic        par_err_n,
    input  logic        mmu_abt_n,
    input  logic        cc_err_n,
    output logic [15:0] ad_out,
    output logic        ad_oe,
    output logic        evnt_pend
);

    svc_state_e  state_q, state_d;
    logic [15:0] word_q, word_d;
    logic        halt_q, halt_d;
    logic        tmo_q, tmo_d;
    logic        evnt_q, evnt_d;
    logic        m11_oe_q, m11_out_q;
    logic        svc_rd, cjmp, ltc_tick, clr;
    logic        mib_unused;

    assign svc_rd = mib_vld & ~mib_in[13] & ~mib_in[6] & ~mib_in[5];
    assign cjmp   = mib_vld & (mib_in[15:11] == CJMP_OP);
    assign mib_unused = ^{mib_in[10:7], mib_in[4:0]};

`ifdef DC_SVC_LTC_EN
    dc_svc_ltc #(
        .LTC_DIV (LTC_DIV)
    ) u_ltc (
        .clk  (clk),
        .rst  (rst),
        .tick (ltc_tick)
    );
`else
    logic ltc_unused;
    assign ltc_unused = ^LTC_DIV;
    assign ltc_tick   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        clr     = (state_q == ST_CLEAR);
        // A source asserting in the clear cycle re-sets its latch.
        halt_d  = (halt_q & ~(clr & word_q[B_HALT])) | halt_req;
        tmo_d   = (tmo_q  & ~(clr & word_q[B_TMO]))  | bus_tmo;
        evnt_d  = (evnt_q & ~(clr & word_q[B_EVNT])) | ltc_tick;
        unique case (state_q)
            ST_IDLE: begin
                if (svc_rd) begin
                    state_d                = ST_DRIVE;
                    word_d                 = 16'h0000;
                    word_d[B_EVNT]         = evnt_q;
                    word_d[B_IRQ7:B_IRQ4]  = {irq[0], irq[1], irq[2], irq[3]};
                    word_d[B_ACLO]         = aclo_n;
                    word_d[B_HALT]         = halt_q;
                    word_d[B_CC]           = cc_err_n;
                    word_d[B_MMU]          = mmu_abt_n;
                    word_d[B_PAR]          = par_err_n;
                    word_d[B_TMO]          = tmo_q;
                    word_d[B_DCLO]         = dclo_n;
                end
            end
            ST_DRIVE: state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            word_q    <= 16'h0000;
            halt_q    <= 1'b0;
            tmo_q     <= 1'b0;
            evnt_q    <= 1'b0;
            m11_oe_q  <= 1'b0;
            m11_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            halt_q    <= halt_d;
            tmo_q     <= tmo_d;
            evnt_q    <= evnt_d;
            m11_oe_q  <= cjmp;
            m11_out_q <= cjmp & ~cond;
        end
    end

    assign ad_oe     = (state_q == ST_DRIVE);
    assign ad_out    = ad_oe ? word_q : 16'h0000;
    assign m11_oe    = m11_oe_q;
    assign m11_out   = m11_out_q;
    assign evnt_pend = evnt_q;

endmodule

// File: tb/tb_dc_svc_rsp.sv
// Self-checking bench for dc_svc_rsp (directed scenarios plus random run).
// Build with DC_SVC_LTC_EN defined to exercise the line-clock path.
module tb_dc_svc_rsp;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mib_in;
    logic        mib_vld, cond;
    logic        m11_out, m11_oe;
    logic [3:0]  irq;
    logic        halt_req, bus_tmo, aclo_n, dclo_n;
    logic        par_err_n, mmu_abt_n, cc_err_n;
    logic [15:0] ad_out;
    logic        ad_oe, evnt_pend;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: a transaction is a 2-cycle countdown
    int          m_busy, m_n;
    logic        m_halt, m_tmo, m_evnt, m_m11_oe, m_m11_out;
    logic [15:0] m_word;

    dc_svc_rsp #(.LTC_DIV(16'(DIV))) dut (
        .clk       (clk),
        .rst       (rst),
        .mib_in    (mib_in),
        .mib_vld   (mib_vld),
        .cond      (cond),
        .m11_out   (m11_out),
        .m11_oe    (m11_oe),
        .irq       (irq),
        .halt_req  (halt_req),
        .bus_tmo   (bus_tmo),
        .aclo_n    (aclo_n),
        .dclo_n    (dclo_n),
        .par_err_n (par_err_n),
        .mmu_abt_n (mmu_abt_n),
        .cc_err_n  (cc_err_n),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .evnt_pend (evnt_pend)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] svc_word();
        logic [15:0] w;
        w     = 16'h0000;
        w[12] = m_evnt;
        w[11] = irq[0];
        w[10] = irq[1];
        w[9]  = irq[2];
        w[8]  = irq[3];
        w[7]  = aclo_n;
        w[5]  = m_halt;
        w[4]  = cc_err_n;
        w[3]  = mmu_abt_n;
        w[2]  = par_err_n;
        w[1]  = m_tmo;
        w[0]  = dclo_n;
        return w;
    endfunction

    task automatic model_step();
        bit rd, cj, tk, clr;
        logic nh, nt, ne;
        if (rst) begin
            m_busy = 0; m_n = 0; m_halt = 0; m_tmo = 0; m_evnt = 0;
            m_word = 16'h0000; m_m11_oe = 0; m_m11_out = 0;
            return;
        end
        rd = mib_vld && !mib_in[13] && !mib_in[6] && !mib_in[5];
        cj = mib_vld && (mib_in[15:11] == 5'b00001);
`ifdef DC_SVC_LTC_EN
        tk = ((m_n % DIV) == DIV - 1);
`else
        tk = 1'b0;
`endif
        m_n++;
        clr = (m_busy == 1);
        nh = (m_halt && !(clr && m_word[5]))  || halt_req;
        nt = (m_tmo  && !(clr && m_word[1]))  || bus_tmo;
        ne = (m_evnt && !(clr && m_word[12])) || tk;
        if (m_busy == 0) begin
            if (rd) begin
                m_busy = 2;
                m_word = svc_word();
            end
        end else begin
            m_busy--;
        end
        m_halt = nh; m_tmo = nt; m_evnt = ne;
        m_m11_oe  = cj;
        m_m11_out = cj && !cond;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_in();
        mib_vld = 0; mib_in = 16'h0000; cond = 0; irq = 4'h0;
        halt_req = 0; bus_tmo = 0; aclo_n = 1; dclo_n = 1;
        par_err_n = 0; mmu_abt_n = 0; cc_err_n = 0;
    endtask

    task automatic read_once();
        mib_in = 16'h0000; mib_vld = 1;
        cyc();
        mib_vld = 0;
    endtask

    task automatic test_reset();
        idle_in();
        halt_req = 1; read_once(); halt_req = 0;
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if ({ad_oe, ad_out, m11_oe, m11_out, evnt_pend} !== 20'h0) begin
                n_bad++;
                $display("FAIL reset cyc%0d got oe=%b ad=%h m11=%b%b ev=%b req all 0",
                         i, ad_oe, ad_out, m11_oe, m11_out, evnt_pend);
            end
        end
        rst = 0;
    endtask

    task automatic test_svc_read();
        idle_in();
        halt_req = 1; cyc(); halt_req = 0;
        read_once();
        n_cmp++;
        if (ad_oe !== 1'b1 || (ad_out & 16'hEFFF) !== 16'h00A1) begin
            n_bad++;
            $display("FAIL svc_read got oe=%b ad=%h req oe=1 ad=00A1", ad_oe, ad_out);
        end
        n_cmp++;
        if (ad_out[12] !== m_word[12]) begin
            n_bad++;
            $display("FAIL svc_evnt_bit got %b req %b", ad_out[12], m_word[12]);
        end
        cyc();
        n_cmp++;
        if (ad_oe !== 1'b0 || ad_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL svc_clear got oe=%b ad=%h req 0/0000", ad_oe, ad_out);
        end
        cyc();
        read_once();
        n_cmp++;
        if ((ad_out & 16'hEFFF) !== 16'h0081) begin
            n_bad++;
            $display("FAIL svc_halt_cleared got %h req 0081", ad_out & 16'hEFFF);
        end
        repeat (2) cyc();
    endtask

    task automatic test_cjmp();
        idle_in();
        for (int c = 1; c >= 0; c--) begin
            mib_in = 16'h0800; mib_vld = 1; cond = c[0];
            cyc();
            mib_vld = 0; cond = 0;
            n_cmp++;
            if (m11_oe !== 1'b1 || m11_out !== ~c[0]) begin
                n_bad++;
                $display("FAIL cjmp cond=%0d got oe=%b out=%b req oe=1 out=%b",
                         c, m11_oe, m11_out, ~c[0]);
            end
            cyc();
            n_cmp++;
            if (m11_oe !== 1'b0) begin
                n_bad++;
                $display("FAIL cjmp_one_cycle got oe=%b req 0", m11_oe);
            end
            repeat (2) cyc();
        end
    endtask

    task automatic test_race();
        idle_in();
        bus_tmo = 1; cyc(); bus_tmo = 0;
        read_once();
        n_cmp++;
        if (ad_out[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL race_first got bit1=%b req 1", ad_out[1]);
        end
        cyc();
        bus_tmo = 1; cyc(); bus_tmo = 0;
        read_once();
        n_cmp++;
        if (ad_out[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL race_set_wins got bit1=%b req 1", ad_out[1]);
        end
        repeat (2) cyc();
        read_once();
        n_cmp++;
        if (ad_out[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL race_cleared got bit1=%b req 0", ad_out[1]);
        end
        repeat (2) cyc();
    endtask

    task automatic test_ltc();
        idle_in();
        rst = 1; cyc(); rst = 0;
`ifdef DC_SVC_LTC_EN
        for (int i = 1; i <= DIV; i++) begin
            cyc();
            n_cmp++;
            if (evnt_pend !== (i == DIV)) begin
                n_bad++;
                $display("FAIL ltc_rise cyc%0d got %b req %b", i, evnt_pend, i == DIV);
            end
        end
        read_once();
        n_cmp++;
        if (ad_out[12] !== 1'b1) begin
            n_bad++;
            $display("FAIL ltc_word got bit12=%b req 1", ad_out[12]);
        end
        for (int i = 0; i < 3 * DIV; i++) begin
            cyc();
            n_cmp++;
            if (evnt_pend !== m_evnt) begin
                n_bad++;
                $display("FAIL ltc_track cyc%0d got %b req %b", i, evnt_pend, m_evnt);
            end
        end
`else
        for (int i = 0; i < 3 * DIV; i++) begin
            cyc();
            n_cmp++;
            if (evnt_pend !== 1'b0) begin
                n_bad++;
                $display("FAIL ltc_off_pend cyc%0d got %b req 0", i, evnt_pend);
            end
        end
        read_once();
        n_cmp++;
        if (ad_out[12] !== 1'b0) begin
            n_bad++;
            $display("FAIL ltc_off_word got bit12=%b req 0", ad_out[12]);
        end
        repeat (2) cyc();
`endif
    endtask

    task automatic test_rst_drive();
        idle_in();
        read_once();
        n_cmp++;
        if (ad_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL rstdrv_drive got oe=%b req 1", ad_oe);
        end
        rst = 1; cyc(); rst = 0;
        n_cmp++;
        if (ad_oe !== 1'b0 || ad_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL rstdrv_abort got oe=%b ad=%h req 0/0000", ad_oe, ad_out);
        end
        read_once();
        n_cmp++;
        if (ad_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL rstdrv_idle got oe=%b req 1", ad_oe);
        end
        repeat (2) cyc();
    endtask

    task automatic test_random();
        logic [19:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            mib_vld   = ($urandom_range(0, 2) == 0);
            mib_in    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) mib_in[15:11] = 5'b00001;
            if ($urandom_range(0, 1) == 0) mib_in[13] = 1'b0;
            if ($urandom_range(0, 1) == 0) {mib_in[6], mib_in[5]} = 2'b00;
            cond      = 1'($urandom);
            irq       = 4'($urandom);
            halt_req  = ($urandom_range(0, 7) == 0);
            bus_tmo   = ($urandom_range(0, 7) == 0);
            aclo_n    = 1'($urandom);
            dclo_n    = 1'($urandom);
            par_err_n = 1'($urandom);
            mmu_abt_n = 1'($urandom);
            cc_err_n  = 1'($urandom);
            cyc();
            got = {ad_oe, ad_out, m11_oe, m11_out, evnt_pend};
            exp = {m_busy == 2, (m_busy == 2) ? m_word : 16'h0000,
                   m_m11_oe, m_m11_out, m_evnt};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL random cyc%0d got %h req %h", i, got, exp);
            end
        end
        rst = 0;
        idle_in();
    endtask

    initial begin
        rst = 1;
        idle_in();
        test_reset();
        test_svc_read();
        test_cjmp();
        test_race();
        test_ltc();
        test_rst_drive();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
